// File: rtl/int_arb_pkg.sv
// Shared types and constants for the interrupt arbiter between the I/O page and the CPU.
package int_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACK  = 3'd2,
    ST_VEC  = 3'd3,
    ST_HOLD = 3'd4
  } arb_state_e;

  localparam int unsigned PSW_PRI_LSB = 5;
  localparam int unsigned ACK_W       = 8;

  function automatic logic [ACK_W-1:0] level_onehot(input logic [2:0] lvl);
    return ACK_W'(1) << lvl;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Picks the highest requesting level strictly above the priority threshold; level 0 never wins.
module int_prio_enc
  import int_arb_pkg::*;
(
  input  logic [ACK_W-1:0] mask_i,
  input  logic [2:0]       thresh_i,
  output logic             any_valid_o,
  output logic [2:0]       level_o
);

  // Ascending scan so the last hit, the highest level, is what remains.
  always_comb begin
    any_valid_o = 1'b0;
    level_o     = '0;
    for (int unsigned n = 1; n < ACK_W; n++) begin
      if (mask_i[n] && (n > 32'(thresh_i))) begin
        any_valid_o = 1'b1;
        level_o     = 3'(n);
      end
    end
  end

endmodule

// File: rtl/int_arb.sv
// Interrupt arbiter: filters I/O page requests against PSW priority, raises one request to the
// CPU, acknowledges the winner on take, presents the captured vector, then holds off.
module int_arb
  import int_arb_pkg::*;
#(
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned PRI_LSB = PSW_PRI_LSB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACK_W-1:0] interrupt_ipl,
  input  logic [7:0]       vector,
  input  logic [15:0]      psw,
  input  logic             cpu_int_take,
  output logic [ACK_W-1:0] ack_ipl,
  output logic             cpu_int_req,
  output logic [2:0]       cpu_int_ipl,
  output logic [7:0]       cpu_int_vector,
  output logic             cpu_vec_valid
);

  arb_state_e       state_q, state_d;
  logic [ACK_W-1:0] ack_q, ack_d;
  logic             req_q, req_d;
  logic [2:0]       ipl_q, ipl_d;
  logic [7:0]       vec_q, vec_d;
  logic             vvalid_q, vvalid_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             any_valid;
  logic [2:0]       win_level;
  logic [2:0]       psw_pri;
  logic             take_hit;
  logic             unused_psw_ok;

  assign psw_pri       = psw[PRI_LSB+2:PRI_LSB];
  assign unused_psw_ok = ^psw;
  assign take_hit      = (state_q == ST_REQ) && cpu_int_take;

  int_prio_enc u_prio_enc (
    .mask_i      (interrupt_ipl),
    .thresh_i    (psw_pri),
    .any_valid_o (any_valid),
    .level_o     (win_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ack_q    <= '0;
      req_q    <= 1'b0;
      ipl_q    <= '0;
      vec_q    <= '0;
      vvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      req_q    <= req_d;
      ipl_q    <= ipl_d;
      vec_q    <= vec_d;
      vvalid_q <= vvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_valid) state_d = ST_REQ;
      ST_REQ: begin
        // A take beats a same-cycle withdraw.
        if (cpu_int_take)    state_d = ST_ACK;
        else if (!any_valid) state_d = ST_IDLE;
      end
      ST_ACK:  state_d = ST_VEC;
      ST_VEC:  state_d = ST_HOLD;
      ST_HOLD: if (cnt_q == 4'd1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d    = (state_d == ST_REQ);
    ipl_d    = (state_d == ST_REQ) ? win_level : ipl_q;
    // Acknowledge the level the CPU saw on its request lines, not the same-cycle winner.
    ack_d    = take_hit ? level_onehot(ipl_q) : '0;
    vec_d    = take_hit ? vector : vec_q;
    vvalid_d = (state_q == ST_ACK);
    cnt_d    = cnt_q;
    if (state_q == ST_VEC)       cnt_d = 4'(HOLDOFF);
    else if (state_q == ST_HOLD) cnt_d = cnt_q - 4'd1;
  end

  assign ack_ipl        = ack_q;
  assign cpu_int_req    = req_q;
  assign cpu_int_ipl    = ipl_q;
  assign cpu_int_vector = vec_q;
  assign cpu_vec_valid  = vvalid_q;

endmodule
